// File: rtl/stream_downsize.sv
// stream_downsize: narrows a stream of S_KEEP_WIDTH-lane beats into M_KEEP_WIDTH-lane beats, compacting kept lanes.
// Latency: lanes accepted at a clock edge are presented on m_data_out from that edge (valid the following cycle).
// Backpressure: s_ready_out depends combinationally on m_ready_in; outputs hold while m_valid_out && !m_ready_in.
// Build option: define STREAM_DOWNSIZE_PACK_EN to merge residual lanes of non-last beats with the next beat.
module stream_downsize #(
  parameter int T_DATA_WIDTH = 1,
  parameter int S_KEEP_WIDTH = 6,
  parameter int M_KEEP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_in [S_KEEP_WIDTH],
  input  logic [S_KEEP_WIDTH-1:0] s_keep_in,
  input  logic                    s_last_in,
  input  logic                    s_valid_in,
  output logic                    s_ready_out,
  output logic [T_DATA_WIDTH-1:0] m_data_out [M_KEEP_WIDTH],
  output logic [M_KEEP_WIDTH-1:0] m_keep_out,
  output logic                    m_last_out,
  output logic                    m_valid_out,
  input  logic                    m_ready_in
);

  // Worst case: M-1 residual lanes plus one full input beat.
  localparam int BUF_LANES = S_KEEP_WIDTH + M_KEEP_WIDTH - 1;
  localparam int CW        = $clog2(BUF_LANES + 1);

  logic [T_DATA_WIDTH-1:0] lane_buf [BUF_LANES];
  logic [CW-1:0]           count;
  logic                    last_pend;
`ifndef STREAM_DOWNSIZE_PACK_EN
  // Set while the lanes of an accepted beat are still draining; forces its tail out as a partial beat.
  logic                    flush;
`endif

  int                      count_i;
  int                      sent_i;
  int                      after_i;
  int                      ccount_i;
  logic                    xfer;
  logic                    final_xfer;
  logic                    accept;
  logic [T_DATA_WIDTH-1:0] cdat [S_KEEP_WIDTH];
  logic [T_DATA_WIDTH-1:0] nxt_buf [BUF_LANES];
  logic [CW-1:0]           nxt_count;

  assign count_i = int'(count);

  // Output beat: lowest min(count, M) buffered lanes, unused lanes forced to zero.
  always_comb begin
    sent_i = (count_i < M_KEEP_WIDTH) ? count_i : M_KEEP_WIDTH;
    for (int k = 0; k < M_KEEP_WIDTH; k++) begin
      m_data_out[k] = (k < sent_i) ? lane_buf[k] : '0;
      m_keep_out[k] = (k < sent_i);
    end
`ifdef STREAM_DOWNSIZE_PACK_EN
    m_valid_out = (count_i >= M_KEEP_WIDTH) || last_pend;
`else
    m_valid_out = (count_i >= M_KEEP_WIDTH) || last_pend || (flush && (count_i > 0));
`endif
    m_last_out  = last_pend && (count_i <= M_KEEP_WIDTH);
  end

  // Handshake: room for a new beat is judged on the occupancy left after this cycle's pop.
  always_comb begin
    xfer        = m_valid_out && m_ready_in;
    final_xfer  = xfer && m_last_out;
    after_i     = xfer ? (count_i - sent_i) : count_i;
`ifdef STREAM_DOWNSIZE_PACK_EN
    s_ready_out = rst_n && (after_i < M_KEEP_WIDTH) && (!last_pend || final_xfer);
`else
    s_ready_out = rst_n && (after_i == 0) && (!last_pend || final_xfer);
`endif
    accept      = s_valid_in && s_ready_out;
  end

  // Compact the kept input lanes into ascending slots, skipping unkept lanes.
  always_comb begin
    int n;
    n = 0;
    for (int p = 0; p < S_KEEP_WIDTH; p++) begin
      cdat[p] = '0;
    end
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (s_keep_in[i]) begin
        for (int p = 0; p < S_KEEP_WIDTH; p++) begin
          if (p == n) begin
            cdat[p] = s_data_in[i];
          end
        end
        n = n + 1;
      end
    end
    ccount_i = n;
  end

  // Next buffer: shift down by the lanes sent, then append the compacted input after the survivors.
  always_comb begin
    int sent_eff;
    sent_eff = xfer ? sent_i : 0;
    for (int j = 0; j < BUF_LANES; j++) begin
      nxt_buf[j] = '0;
      if (j < after_i) begin
        for (int k = 0; k < BUF_LANES; k++) begin
          if (k == j + sent_eff) begin
            nxt_buf[j] = lane_buf[k];
          end
        end
      end
    end
    if (accept) begin
      for (int p = 0; p < S_KEEP_WIDTH; p++) begin
        if (p < ccount_i) begin
          for (int j = 0; j < BUF_LANES; j++) begin
            if (j == after_i + p) begin
              nxt_buf[j] = cdat[p];
            end
          end
        end
      end
    end
    nxt_count = CW'(after_i + (accept ? ccount_i : 0));
  end

  // State update; reset discards buffered lanes and any pending packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < BUF_LANES; j++) begin
        lane_buf[j] <= '0;
      end
      count     <= '0;
      last_pend <= 1'b0;
`ifndef STREAM_DOWNSIZE_PACK_EN
      flush     <= 1'b0;
`endif
    end else begin
      lane_buf <= nxt_buf;
      count    <= nxt_count;
      if (accept) begin
        last_pend <= s_last_in;
      end else if (final_xfer) begin
        last_pend <= 1'b0;
      end
`ifndef STREAM_DOWNSIZE_PACK_EN
      if (accept) begin
        flush <= (ccount_i != 0);
      end else if (after_i == 0) begin
        flush <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize at default parameters (6 input lanes, 3 output lanes, 1-bit lanes).
// Observed output is packed as {valid, keep[2:0], last, data lane2, lane1, lane0}.
module tb_stream_downsize;

  logic       clk;
  logic       rst_n;
  logic [0:0] s_data_in [6];
  logic [5:0] s_keep_in;
  logic       s_last_in;
  logic       s_valid_in;
  logic       s_ready_out;
  logic [0:0] m_data_out [3];
  logic [2:0] m_keep_out;
  logic       m_last_out;
  logic       m_valid_out;
  logic       m_ready_in;

  logic [7:0] obs;
  assign obs = {m_valid_out, m_keep_out, m_last_out, m_data_out[2], m_data_out[1], m_data_out[0]};

  int total = 0;
  int bad   = 0;

  logic [5:0] stim_keep [4];
  logic [5:0] stim_dat  [4];
  logic       stim_last [4];
  int         stim_n;
  int         stim_acc;
  logic [7:0] cap_obs [8];
  int         cap_cyc [8];
  int         cap_n;
  int         rdy_drop;

  stream_downsize #(
    .T_DATA_WIDTH(1),
    .S_KEEP_WIDTH(6),
    .M_KEEP_WIDTH(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data_in  (s_data_in),
    .s_keep_in  (s_keep_in),
    .s_last_in  (s_last_in),
    .s_valid_in (s_valid_in),
    .s_ready_out(s_ready_out),
    .m_data_out (m_data_out),
    .m_keep_out (m_keep_out),
    .m_last_out (m_last_out),
    .m_valid_out(m_valid_out),
    .m_ready_in (m_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic vld, input logic [5:0] keep, input logic [5:0] dat, input logic last);
    s_valid_in = vld;
    s_keep_in  = keep;
    s_last_in  = last;
    for (int i = 0; i < 6; i++) s_data_in[i] = dat[i];
  endtask

  task automatic set_beat(input int idx, input logic [5:0] keep, input logic [5:0] dat, input logic last);
    stim_keep[idx] = keep;
    stim_dat[idx]  = dat;
    stim_last[idx] = last;
  endtask

  // Drives stim beats honouring s_ready_out with m_ready_in=1 and records every output transfer.
  task automatic run_stim(input int max_cyc);
    logic acc;
    stim_acc   = 0;
    cap_n      = 0;
    rdy_drop   = 0;
    m_ready_in = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (stim_acc < stim_n) drive(1'b1, stim_keep[stim_acc], stim_dat[stim_acc], stim_last[stim_acc]);
      else drive(1'b0, 6'b0, 6'b0, 1'b0);
      acc = s_valid_in && s_ready_out;
      if (!s_ready_out) rdy_drop++;
      if (m_valid_out && m_ready_in && cap_n < 8) begin
        cap_obs[cap_n] = obs;
        cap_cyc[cap_n] = cyc;
        cap_n++;
      end
      if (acc) stim_acc++;
    end
    drive(1'b0, 6'b0, 6'b0, 1'b0);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== 8'b0) begin bad++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 8'b0); end
    total++;
    if (s_ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", s_ready_out); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready_out !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b exp=1", s_ready_out); end
    total++;
    if (obs !== 8'b0) begin bad++; $display("FAIL idle_after_release obs=%b exp=%b", obs, 8'b0); end
  endtask

  task automatic test_full_keep;
    stim_n = 1;
    set_beat(0, 6'b111111, 6'b001101, 1'b1);
    run_stim(6);
    total++;
    if (stim_acc !== 1) begin bad++; $display("FAIL full_accepted got=%0d exp=1", stim_acc); end
    total++;
    if (cap_n !== 2) begin bad++; $display("FAIL full_beats got=%0d exp=2", cap_n); end
    total++;
    if (cap_obs[0] !== 8'b1_111_0_101) begin bad++; $display("FAIL full_beat0 obs=%b exp=%b", cap_obs[0], 8'b1_111_0_101); end
    total++;
    if (cap_obs[1] !== 8'b1_111_1_001) begin bad++; $display("FAIL full_beat1 obs=%b exp=%b", cap_obs[1], 8'b1_111_1_001); end
    total++;
    if (cap_cyc[1] !== cap_cyc[0] + 1) begin bad++; $display("FAIL full_consecutive got=%0d exp=%0d", cap_cyc[1], cap_cyc[0] + 1); end
  endtask

  task automatic test_sparse;
    stim_n = 1;
    set_beat(0, 6'b100101, 6'b101001, 1'b1);
    run_stim(5);
    total++;
    if (cap_n !== 1) begin bad++; $display("FAIL sparse_beats got=%0d exp=1", cap_n); end
    total++;
    if (cap_obs[0] !== 8'b1_111_1_101) begin bad++; $display("FAIL sparse_beat0 obs=%b exp=%b", cap_obs[0], 8'b1_111_1_101); end
  endtask

  task automatic test_pack;
    logic [7:0] e0, e1, e2;
    stim_n = 2;
    set_beat(0, 6'b011111, 6'b010110, 1'b0);
    set_beat(1, 6'b000011, 6'b000011, 1'b1);
`ifdef STREAM_DOWNSIZE_PACK_EN
    e0 = 8'b1_111_0_110; e1 = 8'b1_111_0_110; e2 = 8'b1_001_1_001;
`else
    e0 = 8'b1_111_0_110; e1 = 8'b1_011_0_010; e2 = 8'b1_011_1_011;
`endif
    run_stim(8);
    total++;
    if (stim_acc !== 2) begin bad++; $display("FAIL pack_accepted got=%0d exp=2", stim_acc); end
    total++;
    if (cap_n !== 3) begin bad++; $display("FAIL pack_beats got=%0d exp=3", cap_n); end
    total++;
    if (cap_obs[0] !== e0) begin bad++; $display("FAIL pack_beat0 obs=%b exp=%b", cap_obs[0], e0); end
    total++;
    if (cap_obs[1] !== e1) begin bad++; $display("FAIL pack_beat1 obs=%b exp=%b", cap_obs[1], e1); end
    total++;
    if (cap_obs[2] !== e2) begin bad++; $display("FAIL pack_beat2 obs=%b exp=%b", cap_obs[2], e2); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    m_ready_in = 1'b0;
    drive(1'b1, 6'b111111, 6'b001101, 1'b1);
    total++;
    if (s_ready_out !== 1'b1) begin bad++; $display("FAIL bp_ready_idle got=%b exp=1", s_ready_out); end
    @(negedge clk);
    drive(1'b0, 6'b0, 6'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (obs !== 8'b1_111_0_101 || s_ready_out !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall%0d obs=%b rdy=%b exp=%b rdy=0", k, obs, s_ready_out, 8'b1_111_0_101);
      end
    end
    m_ready_in = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== 8'b1_111_1_001) begin bad++; $display("FAIL bp_beat1 obs=%b exp=%b", obs, 8'b1_111_1_001); end
    @(negedge clk);
    total++;
    if (obs !== 8'b0) begin bad++; $display("FAIL bp_drained obs=%b exp=%b", obs, 8'b0); end
  endtask

  task automatic test_empty;
    stim_n = 1;
    set_beat(0, 6'b000000, 6'b101010, 1'b1);
    run_stim(4);
    total++;
    if (cap_n !== 1) begin bad++; $display("FAIL empty_last_beats got=%0d exp=1", cap_n); end
    total++;
    if (cap_obs[0] !== 8'b1_000_1_000) begin bad++; $display("FAIL empty_last_beat obs=%b exp=%b", cap_obs[0], 8'b1_000_1_000); end
    set_beat(0, 6'b000000, 6'b010101, 1'b0);
    run_stim(4);
    total++;
    if (stim_acc !== 1 || cap_n !== 0) begin bad++; $display("FAIL empty_nolast acc=%0d beats=%0d exp acc=1 beats=0", stim_acc, cap_n); end
    total++;
    if (rdy_drop !== 0) begin bad++; $display("FAIL empty_nolast_ready drops=%0d exp=0", rdy_drop); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    m_ready_in = 1'b0;
    drive(1'b1, 6'b000111, 6'b000101, 1'b0);
    @(negedge clk);
    drive(1'b0, 6'b0, 6'b0, 1'b0);
    total++;
    if (obs !== 8'b1_111_0_101) begin bad++; $display("FAIL mid_pending obs=%b exp=%b", obs, 8'b1_111_0_101); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 8'b0 || s_ready_out !== 1'b0) begin bad++; $display("FAIL mid_async_reset obs=%b rdy=%b exp=%b rdy=0", obs, s_ready_out, 8'b0); end
    @(negedge clk);
    rst_n = 1'b1;
    stim_n = 1;
    set_beat(0, 6'b100101, 6'b101001, 1'b1);
    run_stim(5);
    total++;
    if (cap_n !== 1) begin bad++; $display("FAIL mid_after_beats got=%0d exp=1", cap_n); end
    total++;
    if (cap_obs[0] !== 8'b1_111_1_101) begin bad++; $display("FAIL mid_after_beat obs=%b exp=%b", cap_obs[0], 8'b1_111_1_101); end
  endtask

  task automatic test_back_to_back;
    stim_n = 2;
    set_beat(0, 6'b111111, 6'b001101, 1'b1);
    set_beat(1, 6'b100101, 6'b101001, 1'b1);
    run_stim(7);
    total++;
    if (cap_n !== 3) begin bad++; $display("FAIL b2b_beats got=%0d exp=3", cap_n); end
    total++;
    if (cap_obs[0] !== 8'b1_111_0_101 || cap_obs[1] !== 8'b1_111_1_001 || cap_obs[2] !== 8'b1_111_1_101) begin
      bad++;
      $display("FAIL b2b_data obs=%b %b %b exp=%b %b %b", cap_obs[0], cap_obs[1], cap_obs[2],
               8'b1_111_0_101, 8'b1_111_1_001, 8'b1_111_1_101);
    end
    total++;
    if (cap_cyc[2] - cap_cyc[0] !== 2) begin bad++; $display("FAIL b2b_no_bubble span=%0d exp=2", cap_cyc[2] - cap_cyc[0]); end
  endtask

  initial begin
    rst_n      = 1'b0;
    m_ready_in = 1'b0;
    drive(1'b0, 6'b0, 6'b0, 1'b0);
    test_reset();
    test_full_keep();
    test_sparse();
    test_pack();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
